// File: rtl/piso_tx_sched.sv
// rtl/piso_tx_sched.sv - two-requester round-robin scheduler feeding a WIDTH-bit PISO
// Sequences IDLE -> LOAD -> SHIFT x WIDTH -> GAP x GAP, with all outputs registered.
module piso_tx_sched #(
    parameter int WIDTH = 4,
    parameter int GAP   = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             REQ0,
    input  logic [WIDTH-1:0] DATA0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] DATA1,
    output logic             ACK0,
    output logic             ACK1,
    output logic [WIDTH-1:0] PISO_IN,
    output logic             PISO_S,
    output logic             FRAME,
    output logic             GNT_ID,
    output logic             BUSY,
    output logic             DONE
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t           state_q;
    logic             last_q;
    logic             gnt_q;
    logic [WIDTH-1:0] hold_q;
    logic             ack0_q;
    logic             ack1_q;
    logic             piso_s_q;
    logic             frame_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    bit_cnt_q;
    logic [3:0]       gap_cnt_q;

    // Both pending: the side that did not win last time gets the grant.
    logic pick_d;
    assign pick_d = (REQ0 && REQ1) ? ~last_q : REQ1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            hold_q    <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            piso_s_q  <= 1'b1;
            frame_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (EN && (REQ0 || REQ1)) begin
                        last_q   <= pick_d;
                        gnt_q    <= pick_d;
                        hold_q   <= pick_d ? DATA1 : DATA0;
                        ack0_q   <= ~pick_d;
                        ack1_q   <= pick_d;
                        piso_s_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    piso_s_q  <= 1'b1;
                    frame_q   <= 1'b1;
                    bit_cnt_q <= '0;
                    state_q   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_cnt_q == CW'(WIDTH - 1)) begin
                        frame_q   <= 1'b0;
                        done_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        if (GAP > 0) begin
                            gap_cnt_q <= '0;
                            state_q   <= ST_GAP;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == 4'(GAP - 1)) begin
                        gap_cnt_q <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ACK0    = ack0_q;
    assign ACK1    = ack1_q;
    assign PISO_IN = hold_q;
    assign PISO_S  = piso_s_q;
    assign FRAME   = frame_q;
    assign GNT_ID  = gnt_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
endmodule

// File: tb/tb_piso_tx_sched.sv
// tb/tb_piso_tx_sched.sv - directed bench for piso_tx_sched (GAP=0 and GAP=2 instances)
module tb_piso_tx_sched;
    localparam int W = 4;
    localparam int K_IDLE = 0, K_LOAD = 1, K_SHIFT = 2, K_GAP = 3;

    logic         CLK, RST, EN, REQ0, REQ1;
    logic [W-1:0] DATA0, DATA1;

    logic         ack0_w [2];
    logic         ack1_w [2];
    logic [W-1:0] pin_w  [2];
    logic         s_w    [2];
    logic         frame_w[2];
    logic         gnt_w  [2];
    logic         busy_w [2];
    logic         done_w [2];

    int checks = 0;
    int errors = 0;

    piso_tx_sched #(.WIDTH(W), .GAP(0)) u_gap0 (
        .CLK(CLK), .RST(RST), .EN(EN),
        .REQ0(REQ0), .DATA0(DATA0), .REQ1(REQ1), .DATA1(DATA1),
        .ACK0(ack0_w[0]), .ACK1(ack1_w[0]), .PISO_IN(pin_w[0]), .PISO_S(s_w[0]),
        .FRAME(frame_w[0]), .GNT_ID(gnt_w[0]), .BUSY(busy_w[0]), .DONE(done_w[0])
    );

    piso_tx_sched #(.WIDTH(W), .GAP(2)) u_gap2 (
        .CLK(CLK), .RST(RST), .EN(EN),
        .REQ0(REQ0), .DATA0(DATA0), .REQ1(REQ1), .DATA1(DATA1),
        .ACK0(ack0_w[1]), .ACK1(ack1_w[1]), .PISO_IN(pin_w[1]), .PISO_S(s_w[1]),
        .FRAME(frame_w[1]), .GNT_ID(gnt_w[1]), .BUSY(busy_w[1]), .DONE(done_w[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // External PISO: loads on S=0, shifts MSB-first otherwise.
    logic [W-1:0] sr[2];
    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (!s_w[i]) sr[i] <= pin_w[i];
            else         sr[i] <= {sr[i][W-2:0], 1'b0};
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    // Model: a frame is a timeline relative to its grant cycle.
    // offset 0 = load, 1..W = shift, W+1..W+G = gap; DONE at offset W+1.
    int           cyc = 0;
    bit           model_on = 0;
    int           gv[2] = '{0, 2};
    int           start_m[2];
    bit           sv_m[2];
    bit           last_m[2];
    bit           gnt_m[2];
    logic [W-1:0] hold_m[2];
    int           kind_m[2];

    function automatic int kind_of(input int off, input int g);
        if (off == 0) return K_LOAD;
        if (off <= W) return K_SHIFT;
        if (off <= W + g) return K_GAP;
        return K_IDLE;
    endfunction

    always @(posedge CLK) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                sv_m[i] = 0; last_m[i] = 1; gnt_m[i] = 0; hold_m[i] = '0; kind_m[i] = K_IDLE;
            end else begin
                if (kind_m[i] == K_IDLE && EN && (REQ0 || REQ1)) begin
                    gnt_m[i]   = (REQ0 && REQ1) ? !last_m[i] : REQ1;
                    last_m[i]  = gnt_m[i];
                    hold_m[i]  = gnt_m[i] ? DATA1 : DATA0;
                    start_m[i] = cyc;
                    sv_m[i]    = 1;
                end
                kind_m[i] = sv_m[i] ? kind_of(cyc - start_m[i], gv[i]) : K_IDLE;
            end
        end
        model_on = 1;
    end

    always @(negedge CLK) begin
        if (model_on) begin
            for (int i = 0; i < 2; i++) begin
                logic [10:0] exp_v, act_v;
                int off;
                off = cyc - start_m[i];
                exp_v = {kind_m[i] == K_LOAD && !gnt_m[i], kind_m[i] == K_LOAD && gnt_m[i],
                         kind_m[i] != K_LOAD, kind_m[i] == K_SHIFT, gnt_m[i],
                         kind_m[i] != K_IDLE, sv_m[i] && off == W + 1, hold_m[i]};
                act_v = {ack0_w[i], ack1_w[i], s_w[i], frame_w[i], gnt_w[i],
                         busy_w[i], done_w[i], pin_w[i]};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL model_cmp inst%0d cyc%0d got %03h want %03h (ack0,ack1,s,frame,gnt,busy,done,in)",
                             i, cyc, act_v, exp_v);
                end
                if (kind_m[i] == K_SHIFT) begin
                    checks++;
                    if (sr[i][W-1] !== hold_m[i][W-off]) begin
                        errors++;
                        $display("FAIL piso_out inst%0d cyc%0d got %0b want %0b",
                                 i, cyc, sr[i][W-1], hold_m[i][W-off]);
                    end
                end
            end
        end
    end

    int           nack, prev, nfr, ndone, seen;
    bit           found;
    logic [W-1:0] pat;

    initial begin
        RST = 1; EN = 0; REQ0 = 0; REQ1 = 0; DATA0 = '0; DATA1 = '0;
        repeat (2) @(negedge CLK);
        chk("rst_busy", busy_w[0], 0);
        chk("rst_s", s_w[0], 1);
        chk("rst_in", pin_w[0], 0);
        chk("rst_gnt", gnt_w[0], 0);

        // 1: single frame from requester 0
        RST = 0; REQ0 = 1; DATA0 = 4'b1011; EN = 1;
        @(negedge CLK);
        chk("t1_ack0", ack0_w[0], 1);
        chk("t1_s", s_w[0], 0);
        chk("t1_in", pin_w[0], 11);
        chk("t1_busy", busy_w[0], 1);
        REQ0 = 0;
        pat = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("t1_frame", frame_w[0], 1);
            chk("t1_bit", sr[0][W-1], pat[3-k]);
        end
        @(negedge CLK);
        chk("t1_done", done_w[0], 1);
        chk("t1_idle", busy_w[0], 0);
        chk("t1_gap_busy", busy_w[1], 1);

        // 2: both requesting, alternating grants every 6 cycles
        RST = 1; @(negedge CLK);
        RST = 0; REQ0 = 1; REQ1 = 1; DATA1 = 4'b0110;
        nack = 0; prev = 0;
        for (int c = 0; c < 40 && nack < 4; c++) begin
            @(negedge CLK);
            chk("t2_overlap", int'(ack0_w[0] & ack1_w[0]), 0);
            if (ack0_w[0] || ack1_w[0]) begin
                chk("t2_gnt", gnt_w[0], nack % 2);
                chk("t2_in", pin_w[0], (nack % 2) ? 6 : 11);
                if (nack > 0) chk("t2_space", c - prev, 6);
                prev = c;
                nack++;
            end
        end
        chk("t2_count", nack, 4);
        REQ0 = 0; REQ1 = 0;
        repeat (12) @(negedge CLK);

        // 3: EN low blocks grants; dropping EN mid-frame does not cut the frame
        EN = 0; REQ1 = 1; seen = 0;
        repeat (10) begin
            @(negedge CLK);
            if (ack1_w[0] || busy_w[0]) seen = 1;
        end
        chk("t3_blocked", seen, 0);
        EN = 1; found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge CLK);
            found = ack1_w[0];
        end
        chk("t3_start", found, 1);
        REQ1 = 0; nfr = 0; ndone = 0;
        @(negedge CLK); nfr += frame_w[0];
        @(negedge CLK); nfr += frame_w[0];
        EN = 0;
        repeat (6) begin
            @(negedge CLK);
            nfr += frame_w[0];
            ndone += done_w[0];
        end
        chk("t3_frames", nfr, 4);
        chk("t3_done", ndone, 1);

        // 4: reset in the 2nd FRAME cycle
        EN = 1; REQ0 = 1; found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge CLK);
            found = ack0_w[0];
        end
        chk("t4_start", found, 1);
        REQ0 = 0;
        @(negedge CLK); @(negedge CLK);
        RST = 1;
        @(negedge CLK);
        chk("t4_frame", frame_w[0], 0);
        chk("t4_busy", busy_w[0], 0);
        chk("t4_s", s_w[0], 1);
        chk("t4_in", pin_w[0], 0);
        chk("t4_done", done_w[0], 0);
        RST = 0; REQ0 = 1; REQ1 = 1;
        @(negedge CLK);
        chk("t4_ack0", ack0_w[0], 1);
        chk("t4_ack1", ack1_w[0], 0);
        chk("t4_gnt", gnt_w[0], 0);
        REQ0 = 0; REQ1 = 0;
        repeat (12) @(negedge CLK);

        // 5: GAP=2 instance with continuous REQ0, period 8
        REQ0 = 1; found = 0;
        for (int c = 0; c < 12 && !found; c++) begin
            @(negedge CLK);
            found = ack0_w[1];
        end
        chk("t5_start", found, 1);
        repeat (4) @(negedge CLK);
        @(negedge CLK);
        chk("t5_g1_busy", busy_w[1], 1);
        chk("t5_g1_frame", frame_w[1], 0);
        chk("t5_g1_done", done_w[1], 1);
        @(negedge CLK);
        chk("t5_g2_busy", busy_w[1], 1);
        chk("t5_g2_frame", frame_w[1], 0);
        chk("t5_g2_done", done_w[1], 0);
        @(negedge CLK);
        chk("t5_idle", busy_w[1], 0);
        @(negedge CLK);
        chk("t5_period", ack0_w[1], 1);
        REQ0 = 0;
        repeat (14) @(negedge CLK);

        // 6: short REQ1 pulse during a frame is never granted
        REQ0 = 1; found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge CLK);
            found = ack0_w[0];
        end
        chk("t6_start", found, 1);
        REQ0 = 0;
        @(negedge CLK);
        REQ1 = 1;
        @(negedge CLK);
        REQ1 = 0; nack = 0;
        repeat (12) begin
            @(negedge CLK);
            nack += ack0_w[0] + ack1_w[0];
        end
        chk("t6_no_ack", nack, 0);
        chk("t6_idle", busy_w[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
